armleo_bus_scheduler: RTL and testbench
=======================================

ARMLEO_BUS_SCHEDULER -- requirements
Module: armleo_bus_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning number of requesters (2..16).
REQ-002 The block SHALL have parameter AW, default 32, meaning address width.
REQ-003 The block SHALL have parameter DW, default 32, meaning data width.
REQ-004 The block SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have port m_req_valid  in  N  per-requester command valid.
REQ-007 The block SHALL have port m_req_ready  out  N  per-requester command accepted.
REQ-008 The block SHALL have port m_req_write  in  N  per-requester write flag.
REQ-009 The block SHALL have port m_req_addr  in  N*AW  packed addresses, requester i at bits [i*AW +: AW].
REQ-010 The block SHALL have port m_req_wdata  in  N*DW  packed write data, same packing.
REQ-011 The block SHALL have port m_rsp_valid  out  N  per-requester response strobe.
REQ-012 The block SHALL have port m_rsp_rdata  out  DW  shared read data, valid only with m_rsp_valid.
REQ-013 The block SHALL have ports s_req_valid out 1, s_req_ready in 1, s_req_write out 1, s_req_addr out AW, s_req_wdata out DW: single downstream command channel.
REQ-014 The block SHALL have ports s_rsp_valid in 1, s_rsp_rdata in DW: downstream response.
REQ-015 The block SHALL have ports busy out 1 (state != IDLE), owner_idx out clog2(N) (current owner), proto_err out 1 (sticky).

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_RSP; at most one transaction outstanding.
REQ-017 IDLE: if any m_req_valid, select winner by round-robin starting at pointer ptr, register owner_idx, go ISSUE; else stay.
REQ-018 Winner SHALL be the first set m_req_valid bit scanning ptr, ptr+1, ... wrapping modulo N.
REQ-019 ISSUE: s_req_valid=1; s_req_write/addr/wdata SHALL be the owner's fields muxed combinationally; requester holds them stable until accepted.
REQ-020 ISSUE: when s_req_ready=1, m_req_ready[owner]=1 in the same cycle (only that bit), go WAIT_RSP.
REQ-021 ISSUE: if m_req_valid[owner] drops before acceptance, the block SHALL keep issuing and set proto_err.
REQ-022 WAIT_RSP: when s_rsp_valid=1, m_rsp_valid[owner]=1 and m_rsp_rdata=s_rsp_rdata that cycle, ptr <= (owner+1) mod N, go IDLE.
REQ-023 s_rsp_valid in IDLE or ISSUE SHALL be dropped, never forwarded, and SHALL set proto_err.
REQ-024 Minimum transaction SHALL take 3 cycles (arbitrate, issue, response); back-to-back grants SHALL restart from IDLE.
REQ-025 ptr SHALL update only on response completion; owner_idx SHALL hold from grant to return to IDLE.
REQ-026 All m_req_ready/m_rsp_valid bits other than owner SHALL be 0 at all times.

Reset
REQ-027 On rst: state=IDLE, ptr=0, owner_idx=0, proto_err=0; all valid/ready outputs 0 in the reset cycle and the following cycle.
REQ-028 rst mid-transaction SHALL abandon it: no m_req_ready/m_rsp_valid issued for it afterwards.

Structure
REQ-029 Package armleo_bus_sched_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT_RSP) and the clog2 index-width helper.
REQ-030 Combinational rotate-priority picker SHALL be sub-module armleo_rr_pick (inputs request, ptr; outputs onehot, idx, any).

Verification
REQ-031 N=4, reset, m_req_valid=4'b1111 held, s_req_ready=1, s_rsp_valid one cycle after accept -> owner order 0,1,2,3,0.
REQ-032 ptr=3 (after serving 2), m_req_valid=4'b0011 -> owner 0 (wrap), then owner 1.
REQ-033 Owner 1 read, s_req_ready low 5 cycles -> s_req_valid held 6 cycles, m_req_ready[1] pulses once; rdata 0xDEADBEEF -> m_rsp_valid=4'b0010, m_rsp_rdata=0xDEADBEEF.
REQ-034 s_rsp_valid pulsed in IDLE -> no m_rsp_valid, proto_err=1 and stays 1 until rst.
REQ-035 rst asserted in WAIT_RSP, response arrives next cycle -> no m_rsp_valid, state IDLE, ptr=0, proto_err=0.
REQ-036 Single requester 2 continuously valid -> served every 3 cycles with zero-wait slave, owner_idx=2 throughout.

Source files
------------

// File: rtl/armleo_bus_sched_pkg.sv
// Shared types and helpers for the bus scheduler: FSM state encoding and
// the owner-index width calculation.
package armleo_bus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } sched_state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/armleo_rr_pick.sv
// Combinational rotate-priority picker: first set request bit scanning from
// ptr upward, wrapping modulo N.
module armleo_rr_pick
    import armleo_bus_sched_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  request,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] w_pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        w_pos  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = IW'((32'(ptr) + k) % N);
            if (!any && request[w_pos]) begin
                any           = 1'b1;
                idx           = w_pos;
                onehot[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/armleo_bus_scheduler.sv
// Round-robin scheduler funnelling N requesters onto one downstream command
// channel with a single outstanding transaction.
module armleo_bus_scheduler
    import armleo_bus_sched_pkg::*;
#(
    parameter  int unsigned N  = 4,
    parameter  int unsigned AW = 32,
    parameter  int unsigned DW = 32,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [N-1:0]    m_req_valid,
    output logic [N-1:0]    m_req_ready,
    input  logic [N-1:0]    m_req_write,
    input  logic [N*AW-1:0] m_req_addr,
    input  logic [N*DW-1:0] m_req_wdata,
    output logic [N-1:0]    m_rsp_valid,
    output logic [DW-1:0]   m_rsp_rdata,

    output logic            s_req_valid,
    input  logic            s_req_ready,
    output logic            s_req_write,
    output logic [AW-1:0]   s_req_addr,
    output logic [DW-1:0]   s_req_wdata,
    input  logic            s_rsp_valid,
    input  logic [DW-1:0]   s_rsp_rdata,

    output logic            busy,
    output logic [IW-1:0]   owner_idx,
    output logic            proto_err
);

    sched_state_t  r_state;
    sched_state_t  w_state_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_owner;
    logic [N-1:0]  r_owner_oh;
    logic          r_proto_err;
    logic          r_rst_d;

    logic [N-1:0]  w_pick_onehot;
    logic [IW-1:0] w_pick_idx;
    logic          w_pick_any;
    logic          w_grant;
    logic          w_done;
    logic          w_err;

    armleo_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .request (m_req_valid),
        .ptr     (r_ptr),
        .onehot  (w_pick_onehot),
        .idx     (w_pick_idx),
        .any     (w_pick_any)
    );

    assign s_req_write = m_req_write[r_owner];
    assign s_req_addr  = m_req_addr[r_owner*AW +: AW];
    assign s_req_wdata = m_req_wdata[r_owner*DW +: DW];
    assign m_rsp_rdata = s_rsp_rdata;
    assign busy        = (r_state != IDLE);
    assign owner_idx   = r_owner;
    assign proto_err   = r_proto_err;

    // A response straggling in the cycle right after reset belongs to the
    // abandoned transaction and is dropped silently rather than flagged.
    assign w_err = ((r_state == ISSUE) && !m_req_valid[r_owner]) ||
                   (s_rsp_valid && (r_state != WAIT_RSP) && !r_rst_d);

    always_comb begin
        w_state_nxt = r_state;
        s_req_valid = 1'b0;
        m_req_ready = '0;
        m_rsp_valid = '0;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                s_req_valid = 1'b1;
                if (s_req_ready) begin
                    m_req_ready = r_owner_oh;
                    w_state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (s_rsp_valid) begin
                    m_rsp_valid = r_owner_oh;
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Reset squashes all handshakes combinationally in the reset cycle.
        if (rst) begin
            s_req_valid = 1'b0;
            m_req_ready = '0;
            m_rsp_valid = '0;
            w_grant     = 1'b0;
            w_done      = 1'b0;
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_owner_oh  <= '0;
            r_proto_err <= 1'b0;
            r_rst_d     <= 1'b1;
        end else begin
            r_rst_d <= 1'b0;
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner    <= w_pick_idx;
                r_owner_oh <= w_pick_onehot;
            end
            if (w_done) begin
                r_ptr <= (r_owner == IW'(N - 1)) ? '0 : r_owner + 1'b1;
            end
            if (w_err) begin
                r_proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_armleo_bus_scheduler.sv
// Self-checking bench for armleo_bus_scheduler (N=4): table of transactions
// plus hand sequences for protocol errors, reset and streaming.
module tb_armleo_bus_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   m_req_valid;
    logic [3:0]   m_req_ready;
    logic [3:0]   m_req_write;
    logic [127:0] m_req_addr;
    logic [127:0] m_req_wdata;
    logic [3:0]   m_rsp_valid;
    logic [31:0]  m_rsp_rdata;
    logic         s_req_valid;
    logic         s_req_ready;
    logic         s_req_write;
    logic [31:0]  s_req_addr;
    logic [31:0]  s_req_wdata;
    logic         s_rsp_valid;
    logic [31:0]  s_rsp_rdata;
    logic         busy;
    logic [1:0]   owner_idx;
    logic         proto_err;

    armleo_bus_scheduler #(
        .N  (4),
        .AW (32),
        .DW (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_write (m_req_write),
        .m_req_addr  (m_req_addr),
        .m_req_wdata (m_req_wdata),
        .m_rsp_valid (m_rsp_valid),
        .m_rsp_rdata (m_rsp_rdata),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_write (s_req_write),
        .s_req_addr  (s_req_addr),
        .s_req_wdata (s_req_wdata),
        .s_rsp_valid (s_rsp_valid),
        .s_rsp_rdata (s_rsp_rdata),
        .busy        (busy),
        .owner_idx   (owner_idx),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        int          delay;
        logic [31:0] rdata;
        int          owner;
    } vec_t;

    typedef struct {
        int          owner;
        logic [31:0] rdata;
    } sb_t;

    vec_t       tbl[12];
    sb_t        sb_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] write_map = 4'b0101;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic chk_rsp();
        sb_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("rsp_valid", 32'(m_rsp_valid), 32'd1 << e.owner);
            chk("rsp_rdata", m_rsp_rdata, e.rdata);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_req_valid = '0;
        s_req_ready = 1'b0;
        s_rsp_valid = 1'b0;
        #1;
        chk("rst_outs", {s_req_valid, m_req_ready, m_rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner_idx), 32'd0);
        chk("rst_err", 32'(proto_err), 32'd0);
        @(posedge clk); #1;
        chk("rst_outs2", {s_req_valid, m_req_ready, m_rsp_valid}, 32'd0);
    endtask

    // Assumes DUT idle on entry; leaves it idle on exit.
    task automatic run_txn(input logic [3:0] mask, input int delay,
                           input logic [31:0] rdata, input int eo);
        int nv = 0;
        int nr = 0;
        m_req_valid = mask;
        s_req_ready = 1'b0;
        s_rsp_valid = 1'b0;
        @(posedge clk); #1;
        chk("grant_owner", 32'(owner_idx), 32'(eo));
        chk("grant_busy", 32'(busy), 32'd1);
        chk("s_addr", s_req_addr, 32'h1000_0000 + 32'(eo) * 16);
        chk("s_wdata", s_req_wdata, 32'hA5A5_0000 + 32'(eo));
        chk("s_write", 32'(s_req_write), 32'(write_map[eo]));
        for (int c = 0; c < delay; c++) begin
            if (s_req_valid) nv++;
            if (m_req_ready != 4'b0) nr++;
            @(posedge clk); #1;
        end
        s_req_ready = 1'b1;
        #1;
        if (s_req_valid) nv++;
        chk("req_ready", 32'(m_req_ready), 32'd1 << eo);
        if (m_req_ready[eo]) nr++;
        sb_q.push_back('{eo, rdata});
        @(posedge clk); #1;
        s_req_ready = 1'b0;
        chk("issue_cycles", 32'(nv), 32'(delay + 1));
        chk("ready_pulses", 32'(nr), 32'd1);
        chk("wait_sreq", 32'(s_req_valid), 32'd0);
        s_rsp_valid = 1'b1;
        s_rsp_rdata = rdata;
        #1;
        chk_rsp();
        @(posedge clk); #1;
        s_rsp_valid = 1'b0;
        chk("back_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int prev;
        int npulse;

        tbl[0]  = '{4'b1111, 0, 32'h1111_0000, 0};
        tbl[1]  = '{4'b1111, 0, 32'h1111_0001, 1};
        tbl[2]  = '{4'b1111, 0, 32'h1111_0002, 2};
        tbl[3]  = '{4'b1111, 0, 32'h1111_0003, 3};
        tbl[4]  = '{4'b1111, 0, 32'h1111_0004, 0};
        tbl[5]  = '{4'b0100, 1, 32'h2222_0005, 2};
        tbl[6]  = '{4'b0011, 0, 32'h3333_0006, 0};
        tbl[7]  = '{4'b0011, 0, 32'h3333_0007, 1};
        tbl[8]  = '{4'b0010, 5, 32'hDEAD_BEEF, 1};
        tbl[9]  = '{4'b1000, 2, 32'h4444_0009, 3};
        tbl[10] = '{4'b1010, 0, 32'h5555_000A, 1};
        tbl[11] = '{4'b1001, 0, 32'h6666_000B, 3};

        m_req_write = write_map;
        for (int i = 0; i < 4; i++) begin
            m_req_addr[i*32 +: 32]  = 32'h1000_0000 + 32'(i) * 16;
            m_req_wdata[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
        end
        s_rsp_rdata = '0;
        do_reset();

        for (int i = 0; i < 12; i++)
            run_txn(tbl[i].mask, tbl[i].delay, tbl[i].rdata, tbl[i].owner);

        // Response while idle: dropped, sticky error.
        do_reset();
        s_rsp_valid = 1'b1;
        s_rsp_rdata = 32'h0BAD_0BAD;
        #1;
        chk("idle_rsp_drop", 32'(m_rsp_valid), 32'd0);
        @(posedge clk); #1;
        s_rsp_valid = 1'b0;
        chk("idle_rsp_err", 32'(proto_err), 32'd1);
        chk("idle_rsp_busy", 32'(busy), 32'd0);
        run_txn(4'b1111, 1, 32'hCAFE_0001, 0);
        chk("err_sticky", 32'(proto_err), 32'd1);
        do_reset();

        // Owner drops valid before acceptance: keep issuing, flag error.
        m_req_valid = 4'b0001;
        @(posedge clk); #1;
        chk("drop_owner", 32'(owner_idx), 32'd0);
        m_req_valid = 4'b0000;
        @(posedge clk); #1;
        chk("drop_sreq", 32'(s_req_valid), 32'd1);
        chk("drop_err", 32'(proto_err), 32'd1);
        s_req_ready = 1'b1;
        #1;
        chk("drop_ready", 32'(m_req_ready), 32'd1);
        sb_q.push_back('{0, 32'h7777_0000});
        @(posedge clk); #1;
        s_req_ready = 1'b0;
        s_rsp_valid = 1'b1;
        s_rsp_rdata = 32'h7777_0000;
        #1;
        chk_rsp();
        @(posedge clk); #1;
        s_rsp_valid = 1'b0;
        do_reset();

        // Reset in WAIT_RSP, response arrives the following cycle.
        m_req_valid = 4'b0100;
        @(posedge clk); #1;
        s_req_ready = 1'b1;
        @(posedge clk); #1;
        s_req_ready = 1'b0;
        m_req_valid = 4'b0000;
        chk("abort_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_rst_outs", {s_req_valid, m_req_ready, m_rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        s_rsp_valid = 1'b1;
        s_rsp_rdata = 32'h8888_0000;
        #1;
        chk("abort_no_rsp", 32'(m_rsp_valid), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_owner", 32'(owner_idx), 32'd0);
        @(posedge clk); #1;
        s_rsp_valid = 1'b0;
        chk("abort_err", 32'(proto_err), 32'd0);
        run_txn(4'b1111, 0, 32'h9999_0000, 0);

        // Single requester streaming with a zero-wait slave.
        m_req_valid = 4'b0100;
        s_req_ready = 1'b1;
        prev = -1;
        npulse = 0;
        for (int c = 0; c < 12; c++) begin
            s_rsp_valid = busy && !s_req_valid;
            s_rsp_rdata = 32'h2000 + 32'(c);
            #1;
            if (busy) chk("stream_owner", 32'(owner_idx), 32'd2);
            if (s_req_valid && s_req_ready) sb_q.push_back('{2, 32'h2000 + 32'(c) + 1});
            if (m_rsp_valid != 4'b0) begin
                chk_rsp();
                if (prev >= 0) chk("stream_spacing", 32'(c - prev), 32'd3);
                prev = c;
                npulse++;
            end
            @(posedge clk); #1;
        end
        m_req_valid = 4'b0000;
        s_req_ready = 1'b0;
        s_rsp_valid = 1'b0;
        chk("stream_count", 32'(npulse), 32'd4);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
